timer_irq_source: RTL and testbench

- Memory-mapped down-counting timer on the CPU data bus; drives the CPU `interrupt` input.
- Occupies 16 bytes at BASE: CTRL, PRESET, COUNT.
- Software programs it with sw/lw. An interrupt handler acknowledges it by writing CTRL.

---
 rtl/timer_irq_source.sv | 126 ++++++++++++
 tb/tb_timer_irq_source.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_source.sv
// Memory-mapped down-counting timer that raises a level interrupt to the CPU.
// Registers at BASE: CTRL (+0), PRESET (+4), COUNT (+8, read-only), reserved (+C).
module timer_irq_source #(
   parameter logic [31:0] BASE = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CNT,
      ST_INT
   } state_t;

   state_t              state, state_next;
   logic                en, en_next;
   logic [1:0]          mode, mode_next;
   logic                im, im_next;
   logic                pending, pending_next;
   logic [DATA_W-1:0]   preset, preset_next;
   logic [DATA_W-1:0]   count, count_next;

   logic                sel;
   logic                wr_ctrl;
   logic                wr_preset;
   logic                unused_addr_bits;

   assign sel       = (addr[31:4] == BASE[31:4]);
   assign wr_ctrl   = sel && we && (addr[3:2] == 2'd0);
   assign wr_preset = sel && we && (addr[3:2] == 2'd1);
   assign unused_addr_bits = &{1'b0, addr[1:0]};

   assign irq = im & pending;

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (addr[3:2])
            2'd0:    rdata = {28'd0, im, mode, en};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         en      <= 1'b0;
         mode    <= 2'd0;
         im      <= 1'b0;
         pending <= 1'b0;
         preset  <= '0;
         count   <= '0;
      end else begin
         state   <= state_next;
         en      <= en_next;
         mode    <= mode_next;
         im      <= im_next;
         pending <= pending_next;
         preset  <= preset_next;
         count   <= count_next;
      end
   end

   always_comb begin
      state_next   = state;
      en_next      = en;
      mode_next    = mode;
      im_next      = im;
      pending_next = pending;
      preset_next  = preset;
      count_next   = count;

      case (state)
         ST_IDLE: begin
            if (en) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            count_next = preset;
            state_next = ST_CNT;
         end
         ST_CNT: begin
            if (!en) begin
               state_next = ST_IDLE;
            end else if (count == '0) begin
               state_next   = ST_INT;
               pending_next = 1'b1;
            end else begin
               count_next = count - 32'd1;
            end
         end
         ST_INT: begin
            // Only mode 01 reloads; modes 00, 10 and 11 are one-shot.
            if (mode == 2'b01) begin
               state_next   = ST_LOAD;
               pending_next = 1'b0;
            end else begin
               en_next    = 1'b0;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Software writes come last so they win over any hardware update in the same cycle.
      if (wr_ctrl) begin
         en_next      = wdata[0];
         mode_next    = wdata[2:1];
         im_next      = wdata[3];
         pending_next = 1'b0;
      end
      if (wr_preset) preset_next = wdata;
   end

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed self-checking bench for timer_irq_source.
module tb_timer_irq_source;

   localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
   localparam logic [31:0] A_PRESET = 32'h0000_7F04;
   localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
   localparam logic [31:0] A_RSV    = 32'h0000_7F0C;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int total;
   int bad;
   logic [31:0] v;

   timer_irq_source #(.BASE(32'h0000_7F00)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we    = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      we   = 1'b0;
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic test_reset;
      step(3);
      @(negedge clk);
      reset = 1'b1;
      step(1);
      rd(A_CTRL, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", v, 32'd0); end
      rd(A_PRESET, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_preset got=%h exp=%h", v, 32'd0); end
      rd(A_COUNT, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_count got=%h exp=%h", v, 32'd0); end
      step(1);
      rd(A_RSV, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_rsv got=%h exp=%h", v, 32'd0); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
   endtask

   task automatic test_one_shot;
      wr(A_PRESET, 32'd5);
      wr(A_CTRL, 32'h9);                    // E0
      step(2);                              // E2: CNT with COUNT=PRESET
      rd(A_COUNT, v);
      total++; if (v !== 32'd5) begin bad++; $display("FAIL os_count_e2 got=%0d exp=5", v); end
      step(5);                              // E7
      total++; if (rdata !== 32'd0) begin bad++; $display("FAIL os_count_e7 got=%0d exp=0", rdata); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL os_irq_e7 got=%b exp=0", irq); end
      step(1);                              // E8
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL os_irq_e8 got=%b exp=1", irq); end
      step(1);                              // E9
      rd(A_CTRL, v);
      total++; if (v !== 32'h8) begin bad++; $display("FAIL os_ctrl_e9 got=%h exp=%h", v, 32'h8); end
      step(3);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL os_irq_held got=%b exp=1", irq); end
      wr(A_CTRL, 32'h0);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL os_irq_ack got=%b exp=0", irq); end
   endtask

   task automatic test_auto_reload;
      logic       exp_irq;
      logic [31:0] exp_cnt;
      int ph;
      wr(A_PRESET, 32'd2);
      wr(A_CTRL, 32'hB);                    // E0
      rd(A_COUNT, v);
      for (int k = 1; k <= 24; k++) begin
         step(1);
         exp_irq = (k >= 5) && ((k - 5) % 5 == 0);
         total++;
         if (irq !== exp_irq) begin
            bad++; $display("FAIL ar_irq k=%0d got=%b exp=%b", k, irq, exp_irq);
         end
         if (k >= 2) begin
            ph = (k - 2) % 5;
            exp_cnt = (ph == 0) ? 32'd2 : (ph == 1) ? 32'd1 : 32'd0;
            total++;
            if (rdata !== exp_cnt) begin
               bad++; $display("FAIL ar_count k=%0d got=%0d exp=%0d", k, rdata, exp_cnt);
            end
         end
      end
      wr(A_CTRL, 32'h0);
      step(3);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL ar_stop_irq got=%b exp=0", irq); end
   endtask

   task automatic test_masked;
      logic seen;
      seen = 1'b0;
      wr(A_PRESET, 32'd3);
      wr(A_CTRL, 32'h1);                    // one-shot, IM=0
      for (int k = 1; k <= 10; k++) begin
         step(1);
         if (irq !== 1'b0) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL mask_irq got=1 exp=0"); end
      rd(A_CTRL, v);
      total++; if (v !== 32'h0) begin bad++; $display("FAIL mask_en_cleared got=%h exp=%h", v, 32'h0); end
      wr(A_CTRL, 32'h8);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_unmask_irq got=%b exp=0", irq); end
      step(2);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_unmask_later got=%b exp=0", irq); end
      wr(A_CTRL, 32'h0);
   endtask

   task automatic test_pause_restart;
      logic found;
      found = 1'b0;
      wr(A_PRESET, 32'd10);
      wr(A_CTRL, 32'h9);
      rd(A_COUNT, v);
      for (int k = 0; k < 30 && !found; k++) begin
         step(1);
         if (rdata === 32'd5 && irq === 1'b0) found = 1'b1;
      end
      total++; if (found !== 1'b1) begin bad++; $display("FAIL pause_wait got=timeout exp=count5"); end
      wr(A_CTRL, 32'h8);                    // EN cleared on the edge that takes COUNT to 4
      rd(A_COUNT, v);
      total++; if (v !== 32'd4) begin bad++; $display("FAIL pause_count0 got=%0d exp=4", v); end
      step(4);
      total++; if (rdata !== 32'd4) begin bad++; $display("FAIL pause_hold got=%0d exp=4", rdata); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL pause_irq got=%b exp=0", irq); end
      wr(A_PRESET, 32'd1);
      wr(A_CTRL, 32'h9);                    // E0
      rd(A_COUNT, v);
      step(2);
      total++; if (rdata !== 32'd1) begin bad++; $display("FAIL restart_count got=%0d exp=1", rdata); end
      step(1);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL restart_irq_e3 got=%b exp=0", irq); end
      step(1);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL restart_irq_e4 got=%b exp=1", irq); end
      wr(A_CTRL, 32'h0);
   endtask

   task automatic test_async_reset;
      logic found;
      found = 1'b0;
      wr(A_PRESET, 32'd10);
      wr(A_CTRL, 32'h9);
      rd(A_COUNT, v);
      for (int k = 0; k < 30 && !found; k++) begin
         step(1);
         if (rdata === 32'd7) found = 1'b1;
      end
      total++; if (found !== 1'b1) begin bad++; $display("FAIL rst_wait got=timeout exp=count7"); end
      reset = 1'b0;                         // between edges
      #1;
      total++; if (rdata !== 32'd0) begin bad++; $display("FAIL rst_async_count got=%0d exp=0", rdata); end
      rd(A_CTRL, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL rst_async_ctrl got=%h exp=0", v); end
      rd(A_PRESET, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL rst_async_preset got=%h exp=0", v); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_async_irq got=%b exp=0", irq); end
      @(negedge clk);
      reset = 1'b1;
      wr(A_COUNT, 32'h55);
      rd(A_COUNT, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL count_ro got=%h exp=0", v); end
      wr(A_RSV, 32'hFFFF_FFFF);
      rd(A_RSV, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL rsv_ro got=%h exp=0", v); end
      wr(A_CTRL, 32'hFFFF_FFF6);
      rd(A_CTRL, v);
      total++; if (v !== 32'h6) begin bad++; $display("FAIL ctrl_bits got=%h exp=%h", v, 32'h6); end
      wr(32'h0000_7F14, 32'd123);           // outside the block
      rd(A_PRESET, v);
      total++; if (v !== 32'd0) begin bad++; $display("FAIL unselected_wr got=%0d exp=0", v); end
      wr(A_CTRL, 32'h0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      we    = 1'b0;
      addr  = 32'd0;
      wdata = 32'd0;
      test_reset;
      test_one_shot;
      test_auto_reload;
      test_masked;
      test_pause_restart;
      test_async_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
